// File: rtl/modn_cascade_display_pkg.sv
// Shared seven-segment definitions for the cascaded mod-M display.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package modn_cascade_display_pkg;

   typedef logic [6:0] seg7_t;

   localparam seg7_t SEG_0 = 7'b1000000;
   localparam seg7_t SEG_1 = 7'b1111001;
   localparam seg7_t SEG_2 = 7'b0100100;
   localparam seg7_t SEG_3 = 7'b0110000;
   localparam seg7_t SEG_4 = 7'b0011001;
   localparam seg7_t SEG_5 = 7'b0010010;
   localparam seg7_t SEG_6 = 7'b0000010;
   localparam seg7_t SEG_7 = 7'b1111000;
   localparam seg7_t SEG_8 = 7'b0000000;
   localparam seg7_t SEG_9 = 7'b0010000;
   localparam seg7_t SEG_A = 7'b0001000;
   localparam seg7_t SEG_B = 7'b0000011;
   localparam seg7_t SEG_C = 7'b1000110;
   localparam seg7_t SEG_D = 7'b0100001;
   localparam seg7_t SEG_E = 7'b0000110;
   localparam seg7_t SEG_F = 7'b0001110;

   function automatic seg7_t seg7_decode(input logic [3:0] value);
      seg7_t seg;
      unique case (value)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         default: seg = SEG_F;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/modn_cascade_display_digit.sv
// One mod-M up/down digit with synchronous load; step is the carry/borrow in.
module modn_digit #(
   parameter int N = 4,
   parameter int M = 10
) (
   input  logic         clk_50,
   input  logic         rst_n,
   input  logic         step_i,
   input  logic         up_i,
   input  logic         load_i,
   input  logic [N-1:0] load_digit_i,
   output logic [N-1:0] digit_o,
   output logic         at_terminal_o,
   output logic         carry_o
);

   localparam logic [N-1:0] MAX   = N'(M - 1);
   localparam logic [N:0]   M_EXT = (N+1)'(M);

   logic [N-1:0] digit_q, digit_d;
   logic         at_term;

   always_comb begin
      at_term = up_i ? (digit_q == MAX) : (digit_q == '0);
   end

   always_comb begin
      digit_d = digit_q;
      if (load_i) begin
         // Out-of-range load fields saturate to the top legal digit.
         digit_d = ({1'b0, load_digit_i} >= M_EXT) ? MAX : load_digit_i;
      end else if (step_i) begin
         if (up_i) begin
            digit_d = at_term ? '0 : digit_q + N'(1);
         end else begin
            digit_d = at_term ? MAX : digit_q - N'(1);
         end
      end
   end

   always_ff @(posedge clk_50) begin
      if (!rst_n) begin
         digit_q <= '0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit_o       = digit_q;
   assign at_terminal_o = at_term;
   assign carry_o       = step_i & at_term;

endmodule

// File: rtl/modn_cascade_display.sv
// Prescaled, cascaded mod-M up/down counter with per-digit seven-segment decode.
module modn_cascade_display
   import modn_cascade_display_pkg::*;
#(
   parameter int N      = 4,
   parameter int M      = 10,
   parameter int DIGITS = 4,
   parameter int DIV    = 50000000
) (
   input  logic                  clk_50,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [N*DIGITS-1:0]   load_val,
   output logic                  tick_o,
   output logic                  tc,
   output logic [N*DIGITS-1:0]   cnt_num,
   output logic [7*DIGITS-1:0]   hex
);

   localparam int             PW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0]  PMAX = PW'(DIV - 1);

   logic [PW-1:0]     presc_q, presc_d;
   logic              tick_q, tick_d;
   logic [DIGITS:0]   chain;
   logic [DIGITS-1:0] at_term;

   always_comb begin
      presc_d = presc_q;
      tick_d  = 1'b0;
      if (load) begin
         presc_d = '0;
      end else if (en) begin
         if (presc_q == PMAX) begin
            presc_d = '0;
            tick_d  = 1'b1;
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk_50) begin
      if (!rst_n) begin
         presc_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         tick_q  <= tick_d;
      end
   end

   assign tick_o = tick_q;

   // A load in the same cycle as a registered tick discards that step.
   assign chain[0] = tick_q & ~load;

   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      modn_digit #(
         .N (N),
         .M (M)
      ) u_digit (
         .clk_50        (clk_50),
         .rst_n         (rst_n),
         .step_i        (chain[k]),
         .up_i          (up),
         .load_i        (load),
         .load_digit_i  (load_val[N*k +: N]),
         .digit_o       (cnt_num[N*k +: N]),
         .at_terminal_o (at_term[k]),
         .carry_o       (chain[k+1])
      );

      assign hex[7*k +: 7] = seg7_decode(4'(cnt_num[N*k +: N]));
   end

   assign tc = &at_term;

endmodule
